pipe_wb_buf: RTL and testbench



---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_buf_mem.sv | 32 +++
 rtl/pipe_wb_buf.sv | 131 +++++++++++++
 tb/tb_pipe_wb_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline definitions: datapath widths and the writeback record.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int REC_W  = 1 + DATA_W + IDX_W;

    // Writeback record passed from MEM to WB; wb_e occupies the MSB.
    typedef struct packed {
        logic              wb_e;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } wb_rec_t;

endpackage

// File: rtl/pipe_buf_mem.sv
// Record storage for the MEM->WB buffer: DEPTH entries, one synchronous
// write port and one asynchronous (fall-through) read port. No reset, so
// contents survive reset and flush.
module pipe_buf_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  wb_rec_t       i_wdata,
    input  logic [AW-1:0] i_raddr,
    output wb_rec_t       o_rdata
);

    wb_rec_t r_mem [DEPTH];

    // Write the addressed slot on an accepted push.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Head record is read combinationally.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/pipe_wb_buf.sv
// MEM->WB inter-stage buffer: a small circular FIFO of writeback records
// with push acknowledge, flush, occupancy and sticky error flags.
//
// Handshake toward WB: buf_avail=1 means the head record on wb_e/din/idxin
// is valid this cycle; WB pops it by holding buf_re=1 at a rising edge.
// buf_re is sampled every edge, so N cycles high pops N records. A pop
// while buf_avail=0 does nothing except set udf. Push side: in_we is a
// one-record-per-edge request; in_ack pulses the cycle after acceptance.
module pipe_wb_buf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_we,
    input  logic                     in_wb_e,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IDX_W-1:0]         in_idx,
    output logic                     in_ack,
    output logic                     in_full,
    input  logic                     flush,
    output logic                     buf_avail,
    input  logic                     buf_re,
    output logic                     wb_e,
    output logic [DATA_W-1:0]        din,
    output logic [IDX_W-1:0]         idxin,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    import pipe_pkg::wb_rec_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_ack;
    logic          r_ovf;
    logic          r_udf;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_pop_empty;
    logic          w_push_full;
    wb_rec_t       w_wr_rec;
    wb_rec_t       w_rd_rec;

    // Decode push/pop/error events from the current occupancy.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == CW'(DEPTH));
        w_pop       = buf_re & ~flush & ~w_empty;
        w_pop_empty = buf_re & ~flush & w_empty;
        // A full buffer can still take a push when the head leaves this edge.
        w_push      = in_we & ~flush & (~w_full | w_pop);
        w_push_full = in_we & ~flush & w_full & ~w_pop;
        w_wr_rec.wb_e = in_wb_e;
        w_wr_rec.data = in_data;
        w_wr_rec.idx  = in_idx;
    end

    // Next occupancy: flush empties, otherwise +1 push-only, -1 pop-only.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointers, occupancy, acknowledge pulse and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ack   <= w_push;
            if (flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + PW'(1);
                if (w_pop)  r_rp <= r_rp + PW'(1);
            end
            if (w_push_full) r_ovf <= 1'b1;
            if (w_pop_empty) r_udf <= 1'b1;
        end
    end

    pipe_buf_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata (w_wr_rec),
        .i_raddr (r_rp),
        .o_rdata (w_rd_rec)
    );

    // Status and head presentation; head fields read zero while empty.
    always_comb begin
        count     = r_count;
        buf_avail = ~w_empty;
        in_full   = w_full;
        in_ack    = r_ack;
        ovf       = r_ovf;
        udf       = r_udf;
        wb_e      = w_empty ? 1'b0 : w_rd_rec.wb_e;
        din       = w_empty ? '0   : w_rd_rec.data;
        idxin     = w_empty ? '0   : w_rd_rec.idx;
    end

endmodule

// File: tb/tb_pipe_wb_buf.sv
// Bench for pipe_wb_buf: directed scenarios plus a random phase, checked
// every cycle against a queue-based reference model of the buffer.
module tb_pipe_wb_buf;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int REC_W  = 1 + DATA_W + IDX_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_we;
    logic              in_wb_e;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              in_ack;
    logic              in_full;
    logic              flush;
    logic              buf_avail;
    logic              buf_re;
    logic              wb_e;
    logic [DATA_W-1:0] din;
    logic [IDX_W-1:0]  idxin;
    logic [2:0]        count;
    logic              ovf;
    logic              udf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: queued records in order, plus flags.
    logic [REC_W-1:0] exp_q[$];
    logic             exp_ack;
    logic             exp_ovf;
    logic             exp_udf;

    pipe_wb_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_we     (in_we),
        .in_wb_e   (in_wb_e),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .in_ack    (in_ack),
        .in_full   (in_full),
        .flush     (flush),
        .buf_avail (buf_avail),
        .buf_re    (buf_re),
        .wb_e      (wb_e),
        .din       (din),
        .idxin     (idxin),
        .count     (count),
        .ovf       (ovf),
        .udf       (udf)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of records, updated from the inputs at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_ack = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else if (flush) begin
            exp_q.delete();
            exp_ack = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = buf_re && (exp_q.size() != 0);
            if (buf_re && exp_q.size() == 0) exp_udf = 1'b1;
            do_push = in_we && ((exp_q.size() < DEPTH) || do_pop);
            if (in_we && !do_push) exp_ovf = 1'b1;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({in_wb_e, in_data, in_idx});
            exp_ack = do_push;
        end
    end

    // Monitor: mid-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [REC_W-1:0] head;
            head = (exp_q.size() != 0) ? exp_q[0] : '0;
            check("count",     64'(count),     64'(exp_q.size()));
            check("buf_avail", 64'(buf_avail), 64'(exp_q.size() != 0));
            check("in_full",   64'(in_full),   64'(exp_q.size() == DEPTH));
            check("in_ack",    64'(in_ack),    64'(exp_ack));
            check("ovf",       64'(ovf),       64'(exp_ovf));
            check("udf",       64'(udf),       64'(exp_udf));
            check("head",      64'({wb_e, din, idxin}), 64'(head));
        end
    end

    // Driver: apply one cycle of inputs, return just after the next edge.
    task automatic cyc(input logic we, input logic e, input logic [DATA_W-1:0] d,
                       input logic [IDX_W-1:0] ix, input logic re, input logic fl);
        in_we   = we;
        in_wb_e = e;
        in_data = d;
        in_idx  = ix;
        buf_re  = re;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avail"}, 64'(buf_avail), 64'd0);
        check({tag, "_count"}, 64'(count),     64'd0);
        check({tag, "_ack"},   64'(in_ack),    64'd0);
        check({tag, "_full"},  64'(in_full),   64'd0);
        check({tag, "_ovf"},   64'(ovf),       64'd0);
        check({tag, "_udf"},   64'(udf),       64'd0);
        check({tag, "_head"},  64'({wb_e, din, idxin}), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_we   = 1'b0;
        in_wb_e = 1'b0;
        in_data = '0;
        in_idx  = '0;
        buf_re  = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // Reset mid-stream: two queued records, reset asserted between edges.
        cyc(1'b1, 1'b1, 32'hAAAA_0001, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'hAAAA_0002, 5'd4, 1'b0, 1'b0);
        in_we = 1'b0;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 32'hBEEF_0001, 5'd7, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Fill and drain.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, DATA_W'(i * 32'h11), IDX_W'(i), 1'b0, 1'b0);
        end
        // Overflow: push idx 9 while full, no pop.
        cyc(1'b1, 1'b1, 32'h99, 5'd9, 1'b0, 1'b0);
        // Push while popping at full: accepted, count stays at DEPTH.
        cyc(1'b1, 1'b1, 32'h55, 5'd5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        // Wrap-around at steady occupancy of 2.
        cyc(1'b1, 1'b1, 32'h100, 5'd10, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h101, 5'd11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'(i), DATA_W'(32'h200 + i), IDX_W'(12 + i), 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Underflow, then push+pop on empty.
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 32'h300, 5'd30, 1'b1, 1'b0);
        idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with three queued and a same-cycle push.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, DATA_W'(32'h400 + i), IDX_W'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h4FF, 5'd31, 1'b1, 1'b1);
        idle();
        cyc(1'b1, 1'b0, 32'h500, 5'd2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        // Random traffic with shifting push/pop bias.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 50) % 4;
            cyc(1'($urandom_range(0, 3) < 3 - (bias == 1 ? 2 : 0)),
                1'($urandom_range(0, 1)),
                DATA_W'($urandom),
                IDX_W'($urandom_range(0, 31)),
                1'($urandom_range(0, 3) < 1 + (bias == 1 ? 2 : 0) + (bias == 3 ? 1 : 0)),
                1'($urandom_range(0, 31) == 0));
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
